// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter writing one shared WIDTH-bit register.
// Optional macro ARB_LOCK_EN adds a lock mode where the owner keeps the grant across writes.
module reg_write_arbiter #(
    parameter int  WIDTH = 8,
    localparam int N     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       lock,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   Q,
    output logic [1:0]         owner,
    output logic               busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACK    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [WIDTH-1:0] lane_s [N];
    logic [1:0]       win_s;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_s[i] = data_in[i*WIDTH +: WIDTH];
    end

`ifndef ARB_LOCK_EN
    logic lock_unused_s;
    assign lock_unused_s = ^lock;
`endif

    // Round-robin winner: scan from ptr downwards so the closest requester to ptr overwrites last.
    always_comb begin
        win_s = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win_s = ptr_q + 2'(k);
            end else begin
                win_s = win_s;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    q_d     = lane_s[win_s];
                    gnt_d   = 4'b0001 << win_s;
                    owner_d = win_s;
                    ptr_d   = win_s + 2'd1;
                    state_d = ACK;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            ACK: begin
`ifdef ARB_LOCK_EN
                // A locking owner that refreshes its request keeps the grant and writes again.
                if (lock[owner_q] && req[owner_q]) begin
                    q_d     = lane_s[owner_q];
                    state_d = LOCKED;
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end
`else
                gnt_d   = 4'b0000;
                state_d = IDLE;
`endif
            end
            LOCKED: begin
`ifdef ARB_LOCK_EN
                if (lock[owner_q] && req[owner_q]) begin
                    q_d = lane_s[owner_q];
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end
`else
                gnt_d   = 4'b0000;
                state_d = IDLE;
`endif
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            q_q     <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign Q     = q_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed table-driven bench for reg_write_arbiter (default WIDTH=8).
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [7:0]  Q;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    reg_write_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .lock(lock),
        .gnt(gnt), .Q(Q), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] eg, input logic [7:0] eq,
                           input logic [1:0] eo, input logic eb);
        chk("gnt", idx, 32'(gnt), 32'(eg));
        chk("Q", idx, 32'(Q), 32'(eq));
        chk("owner", idx, 32'(owner), 32'(eo));
        chk("busy", idx, 32'(busy), 32'(eb));
    endtask

    initial begin
        //          rst   req      lock     data           gnt      Q      own   busy
        tv.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0100, 4'b0000, 32'h00A5_0000, 4'b0100, 8'hA5, 2'd2, 1'b1});
        tv.push_back('{1'b0, 4'b0000, 4'b0000, 32'h00FF_0000, 4'b0000, 8'hA5, 2'd2, 1'b0});
        tv.push_back('{1'b0, 4'b1001, 4'b0000, 32'h3000_0010, 4'b1000, 8'h30, 2'd3, 1'b1});
        tv.push_back('{1'b0, 4'b1001, 4'b0000, 32'h3000_0010, 4'b0000, 8'h30, 2'd3, 1'b0});
        tv.push_back('{1'b0, 4'b1001, 4'b0000, 32'h3000_0010, 4'b0001, 8'h10, 2'd0, 1'b1});
        tv.push_back('{1'b0, 4'b0000, 4'b0000, 32'h3000_0010, 4'b0000, 8'h10, 2'd0, 1'b0});
        // reset held across an edge with requests pending, then full round-robin
        tv.push_back('{1'b1, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0000, 8'h00, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0001, 8'h11, 2'd0, 1'b1});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0000, 8'h11, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0010, 8'h22, 2'd1, 1'b1});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0000, 8'h22, 2'd1, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0100, 8'h33, 2'd2, 1'b1});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0000, 8'h33, 2'd2, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b1000, 8'h44, 2'd3, 1'b1});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0000, 8'h44, 2'd3, 1'b0});
        tv.push_back('{1'b0, 4'b1111, 4'b0000, 32'h4433_2211, 4'b0001, 8'h11, 2'd0, 1'b1});
        // req change during ACK is ignored; next IDLE cycle arbitrates from ptr=1
        tv.push_back('{1'b0, 4'b0100, 4'b0000, 32'h4433_2211, 4'b0000, 8'h11, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0100, 4'b0000, 32'h4433_2211, 4'b0100, 8'h33, 2'd2, 1'b1});
        // reset during ACK aborts everything
        tv.push_back('{1'b1, 4'b0100, 4'b0000, 32'h4433_2211, 4'b0000, 8'h00, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0000, 4'b0000, 32'h4433_2211, 4'b0000, 8'h00, 2'd0, 1'b0});
        // requester 1 locks while requester 0 also requests; lane0=E0
        tv.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000_01E0, 4'b0010, 8'h01, 2'd1, 1'b1});
`ifdef ARB_LOCK_EN
        tv.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000_02E0, 4'b0010, 8'h02, 2'd1, 1'b1});
        tv.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000_03E0, 4'b0010, 8'h03, 2'd1, 1'b1});
        tv.push_back('{1'b0, 4'b0011, 4'b0000, 32'h0000_03E0, 4'b0000, 8'h03, 2'd1, 1'b0});
        tv.push_back('{1'b0, 4'b0011, 4'b0000, 32'h0000_03E0, 4'b0001, 8'hE0, 2'd0, 1'b1});
`else
        tv.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000_02E0, 4'b0000, 8'h01, 2'd1, 1'b0});
        tv.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000_03E0, 4'b0001, 8'hE0, 2'd0, 1'b1});
        tv.push_back('{1'b0, 4'b0011, 4'b0000, 32'h0000_03E0, 4'b0000, 8'hE0, 2'd0, 1'b0});
        tv.push_back('{1'b0, 4'b0011, 4'b0000, 32'h0000_03E0, 4'b0010, 8'h03, 2'd1, 1'b1});
`endif

        reset   = 1'b1;
        req     = 4'b0000;
        lock    = 4'b0000;
        data_in = 32'h0;
        #2;
        chk_all(-1, 4'b0000, 8'h00, 2'd0, 1'b0);

        foreach (tv[i]) begin
            @(negedge clk);
            reset   = tv[i].rst;
            req     = tv[i].req;
            lock    = tv[i].lock;
            data_in = tv[i].data;
            @(posedge clk);
            #1;
            chk_all(i, tv[i].gnt, tv[i].q, tv[i].owner, tv[i].busy);
        end

        // asynchronous reset mid-cycle with clk low, DUT busy beforehand
        @(negedge clk);
        req  = 4'b0000;
        lock = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        chk_all(100, 4'b0000, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk_all(101, 4'b0000, 8'h00, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the shared register and of each requester's data lane.
REQ-002 Parameter N is fixed at 4 (requesters); it SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request per requester; bit i = requester i.
REQ-006 data_in  input  4*WIDTH  packed write data; lane i = bits [i*WIDTH +: WIDTH].
REQ-007 lock  input  4  lock request per requester; only meaningful under ARB_LOCK_EN.
REQ-008 gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-009 Q  output  WIDTH  registered content of the shared register.
REQ-010 owner  output  2  index of the last granted requester.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, ACK and LOCKED (LOCKED reachable only under ARB_LOCK_EN).
REQ-013 Round-robin pointer ptr (2 bits): winner = first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
REQ-014 IDLE, req!=0: at the edge, Q <= lane[winner], gnt <= onehot(winner), owner <= winner, ptr <= (winner+1) mod 4, state -> ACK.
REQ-015 IDLE, req==0: Q, owner and ptr SHALL hold, gnt SHALL be 0, state stays IDLE.
REQ-016 Write latency: Q and gnt SHALL both change at the first rising edge that samples a request in IDLE.
REQ-017 ACK: gnt <= 0, state -> IDLE; req is ignored in ACK, so sustained traffic yields at most one write per 2 cycles.
REQ-018 A requester SHALL see gnt[i] high for exactly one cycle per write, and SHALL drop or refresh req[i] at that edge.
REQ-019 Pointer wrap-around: winner 3 SHALL set ptr to 0.
REQ-020 All four requesting continuously SHALL be served in the order 0,1,2,3,0,... from reset.
REQ-021 A req change during ACK SHALL have no effect until the next IDLE cycle.
REQ-022 Q SHALL change only on a grant edge, never on req or data_in change alone.

Reset
REQ-023 Asserting reset SHALL immediately, without a clock edge, force Q=0, gnt=0, owner=0, ptr=0, busy=0 and state IDLE.
REQ-024 Reset asserted during ACK or LOCKED SHALL abort the operation; no partial write of Q SHALL occur.
REQ-025 After reset is deasserted, the first grant edge SHALL be the first rising edge that samples req!=0.

Configuration
REQ-026 Macro ARB_LOCK_EN compiles in the locking feature; the lock port SHALL exist in both builds.
REQ-027 With ARB_LOCK_EN: in ACK, if lock[owner]=1 and req[owner]=1, state -> LOCKED and gnt[owner] SHALL stay high.
REQ-028 LOCKED: each edge with req[owner]=1 SHALL write lane[owner] into Q; other requests SHALL be blocked.
REQ-029 LOCKED: lock[owner]=0 or req[owner]=0 SHALL set gnt <= 0 and state -> IDLE without writing; ptr SHALL stay as set at the grant.
REQ-030 Without ARB_LOCK_EN: lock SHALL be ignored, LOCKED SHALL be unreachable, and behaviour SHALL equal REQ-012..REQ-022.

Verification
REQ-031 Reset asserted mid-cycle with clk low -> Q=0, gnt=0, busy=0 before the next edge.
REQ-032 WIDTH=8; only req[2]=1 with lane2=8'hA5 -> next edge: Q=8'hA5, gnt=4'b0100, owner=2; following edge: gnt=0; ptr=3.
REQ-033 req=4'b1111, lanes 8'h11/22/33/44 held -> grant sequence 0,1,2,3,0 on alternate edges; Q = 11,22,33,44,11.
REQ-034 ptr=3, req=4'b1001 -> requester 3 wins and Q=lane3; next grant goes to requester 0 (wrap).
REQ-035 ARB_LOCK_EN: requester 1 has req=lock=1 while data changes 01,02,03 and req[0]=1 -> Q follows 01,02,03 each cycle, gnt=4'b0010 held; lock drop -> IDLE, then requester 0 is granted.
REQ-036 No ARB_LOCK_EN, same stimulus as REQ-035 -> requester 1 gets a single-cycle grant, and requester 0 wins the next IDLE cycle.
